// File: rtl/block_mem_responder_if.sv
// Line-transfer bus between the cache miss/write-back FSM and the memory responder.
// Purely wiring; no latency of its own.
// The requester holds mem_read/mem_write until mem_ready; the responder never queues.
interface block_mem_responder_if #(
    parameter int ADDR_W = 28
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata;
    logic              mem_ready;

    // Cache side: issues requests and waits for the strobe.
    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    // Memory side: samples requests and returns the strobe and read line.
    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/block_mem_responder.sv
// Memory responder: one 128-bit line read or write at a time against an internal line store.
// Latency: mem_ready is a single-cycle strobe exactly LATENCY cycles after the request's first cycle (1..15).
// Backpressure: none queued; requester holds the request until mem_ready, dropping both strobes while busy aborts.
module block_mem_responder #(
    parameter int ADDR_W  = 28,
    parameter int IDX_W   = 8,
    parameter int LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  proc_reset,
    block_mem_responder_if.slave  mem_if
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int DEPTH = 1 << IDX_W;

    // BUSY lasts LATENCY-1 cycles; the counter holds the BUSY cycles still to run.
    localparam logic [3:0] BUSY_CYCLES = 4'(LATENCY - 1);
    localparam bit         SINGLE_CYC  = (LATENCY == 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             op_wr_q, op_wr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [127:0]     wdata_q, wdata_d;
    logic [127:0]     rdata_q, rdata_d;
    logic             ready_q, ready_d;

    logic [127:0]     line_store [DEPTH];

    logic             req_vld;
    logic             req_none;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [127:0]     rd_line;
    logic             store_we;

    // Upper address bits alias onto the same line; they are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_if.mem_addr[ADDR_W-1:IDX_W];

    assign req_vld  = mem_if.mem_read ^ mem_if.mem_write;
    assign req_none = ~mem_if.mem_read & ~mem_if.mem_write;
    assign req_idx  = mem_if.mem_addr[IDX_W-1:0];

    // With a single-cycle latency RESP is entered straight from IDLE, before the index is latched.
    assign rd_idx   = (state_q == ST_IDLE) ? req_idx : idx_q;
    assign rd_line  = line_store[rd_idx];

    // Writes commit on the edge that ends RESP, so a back-to-back read sees the new line.
    assign store_we = (state_q == ST_RESP) && op_wr_q;

    // Next-state, request latching, countdown and read-line capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_vld) begin
                    op_wr_d = mem_if.mem_write;
                    idx_d   = req_idx;
                    wdata_d = mem_if.mem_wdata;
                    cnt_d   = BUSY_CYCLES;
                    if (SINGLE_CYC) begin
                        state_d = ST_RESP;
                        ready_d = 1'b1;
                        if (!mem_if.mem_write) begin
                            rdata_d = rd_line;
                        end
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end

            ST_BUSY: begin
                if (req_none) begin
                    // Requester withdrew: abandon without a strobe or a store update.
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_RESP;
                        ready_d = 1'b1;
                        if (!op_wr_q) begin
                            rdata_d = rd_line;
                        end
                    end
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; reset clears outputs immediately and drops any pending write.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // Line store: not reset, so contents survive a reset and map onto block RAM.
    always_ff @(posedge clk) begin
        if (store_we) begin
            line_store[idx_q] <= wdata_q;
        end
    end

    assign mem_if.mem_rdata = rdata_q;
    assign mem_if.mem_ready = ready_q;

endmodule

// File: tb/tb_block_mem_responder.sv
// Directed bench for block_mem_responder: four instances at LATENCY 4, 1, 2 and 15.
// Inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
// Requests are held until the ready cycle and dropped right after it.
module tb_block_mem_responder;

    logic         clk;
    logic         rst;
    logic         rd   [4];
    logic         wr   [4];
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic         rdy  [4];
    logic [127:0] rdat [4];

    int lat_of [4] = '{4, 1, 2, 15};

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 15;

        block_mem_responder_if #(.ADDR_W(28)) bus ();

        assign bus.mem_read  = rd[g];
        assign bus.mem_write = wr[g];
        assign bus.mem_addr  = addr;
        assign bus.mem_wdata = wdata;
        assign rdy[g]        = bus.mem_ready;
        assign rdat[g]       = bus.mem_rdata;

        block_mem_responder #(
            .ADDR_W (28),
            .IDX_W  (8),
            .LATENCY(LAT)
        ) dut (
            .clk       (clk),
            .proc_reset(rst),
            .mem_if    (bus.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on instance k at the current cycle (its C0), check ready lands
    // exactly in C_LATENCY, capture mem_rdata there, then release the request.
    task automatic txn(input int k, input bit is_wr, input logic [27:0] a,
                       input logic [127:0] d, input string tag, output logic [127:0] got);
        bit early;
        early = 1'b0;
        got   = 'x;
        addr  = a;
        wdata = d;
        rd[k] = ~is_wr;
        wr[k] = is_wr;
        for (int j = 0; j <= lat_of[k]; j++) begin
            @(negedge clk);
            if (j < lat_of[k]) begin
                if (rdy[k] !== 1'b0) early = 1'b1;
            end else begin
                chk({tag, " ready_at_lat"}, 128'(rdy[k]), 128'd1);
                got = rdat[k];
            end
            @(posedge clk);
            #1;
        end
        chk({tag, " ready_before_lat"}, 128'(early), 128'd0);
        rd[k] = 1'b0;
        wr[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d1, d3, d3b, d7, d9, dx, da, dold, dnew, got, ign;
        bit seen;

        d1   = 128'hDEADBEEF_0000F625_12345678_9ABCDEF0;
        d3   = 128'h33333333_03030303_30303030_C3C3C3C3;
        d3b  = 128'hB3B3B3B3_00000003_FFFF0000_12121212;
        d7   = 128'h77777777_07070707_70707070_A5A5A5A5;
        d9   = 128'h99999999_90000009_01234567_89ABCDEF;
        dx   = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA;
        da   = 128'hA0A0A0A0_0A0A0A0A_FEDCBA98_76543210;
        dold = 128'h01D01D01_D01D01D0_1D01D01D_01D01D01;
        dnew = 128'h0E0E0E0E_E0E0E0E0_5A5A5A5A_A5A5A5A5;

        rst   = 1'b1;
        addr  = '0;
        wdata = '0;
        for (int k = 0; k < 4; k++) begin
            rd[k] = 1'b0;
            wr[k] = 1'b0;
        end

        // Reset state on every instance.
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset ready[%0d]", k), 128'(rdy[k]), 128'd0);
            chk($sformatf("reset rdata[%0d]", k), rdat[k], 128'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write then read the same line, LATENCY=4.
        txn(0, 1'b1, 28'h0000005, d1, "wr5", ign);
        txn(0, 1'b0, 28'h0000005, '0, "rd5", got);
        chk("rd5 data", got, d1);

        // Write-back of idx 3 immediately followed by a refill of idx 7.
        txn(0, 1'b1, 28'h0000007, d7, "wr7", ign);
        txn(0, 1'b1, 28'h0000003, d3, "wb3", ign);
        txn(0, 1'b0, 28'h0000007, '0, "refill7", got);
        chk("refill7 data", got, d7);
        txn(0, 1'b0, 28'h0000003, '0, "rd3", got);
        chk("rd3 updated", got, d3);

        // Back-to-back write and read of the same index returns the new line.
        txn(0, 1'b1, 28'h0000003, d3b, "wr3b", ign);
        txn(0, 1'b0, 28'h0000003, '0, "rd3b", got);
        chk("rd3b data", got, d3b);

        // Both strobes high for 10 cycles: no strobe, no store update.
        addr  = 28'h0000005;
        wdata = dx;
        rd[0] = 1'b1;
        wr[0] = 1'b1;
        seen  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rdy[0] !== 1'b0) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        rd[0] = 1'b0;
        wr[0] = 1'b0;
        chk("illegal ready", 128'(seen), 128'd0);
        chk("illegal rdata held", rdat[0], d3b);
        txn(0, 1'b0, 28'h0000005, '0, "rd5 after illegal", got);
        chk("rd5 store unchanged", got, d1);

        // Abort: read of idx 3 dropped in C2.
        addr  = 28'h0000003;
        rd[0] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rd[0] = 1'b0;
        seen  = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rdy[0] !== 1'b0) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("abort ready", 128'(seen), 128'd0);
        chk("abort rdata held", rdat[0], d1);
        txn(0, 1'b1, 28'h0000009, d9, "wr9 after abort", ign);
        chk("rdata unchanged by write", rdat[0], d1);
        txn(0, 1'b0, 28'h0000009, '0, "rd9", got);
        chk("rd9 data", got, d9);

        // Aliasing with the latency sweep: 0x100 and 0x000 share a line.
        for (int k = 1; k < 4; k++) begin
            txn(k, 1'b1, 28'h0000100, da + 128'(k), $sformatf("alias wr lat%0d", lat_of[k]), ign);
            txn(k, 1'b0, 28'h0000000, '0, $sformatf("alias rd lat%0d", lat_of[k]), got);
            chk($sformatf("alias data lat%0d", lat_of[k]), got, da + 128'(k));
        end

        // Async reset in C2 of a write: outputs clear at once, old line survives.
        txn(0, 1'b1, 28'h0000020, dold, "wr old", ign);
        txn(0, 1'b0, 28'h0000020, '0, "rd old", got);
        chk("rd old data", got, dold);
        addr  = 28'h0000020;
        wdata = dnew;
        wr[0] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        #2;
        rst = 1'b1;
        #1;
        chk("mid-reset ready", 128'(rdy[0]), 128'd0);
        chk("mid-reset rdata", rdat[0], 128'd0);
        wr[0] = 1'b0;
        rd[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("in-reset ready", 128'(rdy[0]), 128'd0);
        rst = 1'b0;
        txn(0, 1'b0, 28'h0000020, '0, "rd after reset", got);
        chk("write discarded by reset", got, dold);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/block_mem_responder.md
# block_mem_responder

Memory-side responder for the cache's 128-bit line interface. It accepts one line read or line write at a time from the cache miss/write-back FSM and returns a single-cycle `mem_ready` after a fixed, parameterised latency. It holds a synthesizable line store, and serves as both the slow-memory model in the CPU testbench and the on-chip backing RAM for FPGA builds.

## Interface
- `ADDR_W`, 28: line address width; matches the cache's `mem_addr`.
- `IDX_W`, 8: line-store index bits; store depth is 2^IDX_W lines.
- `LATENCY`, 4: cycles from the request's first cycle to the `mem_ready` cycle; legal range 1..15.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `proc_reset`, input, 1: reset, asynchronous, active-high.
- `mem_read`, input, 1: line read request; held high until `mem_ready`.
- `mem_write`, input, 1: line write request; held high until `mem_ready`.
- `mem_addr`, input, ADDR_W: line address; bits [IDX_W-1:0] index the store.
- `mem_wdata`, input, 128: write line; word 0 is in [31:0].
- `mem_rdata`, output, 128: read line; registered.
- `mem_ready`, output, 1: completion strobe, exactly one cycle per accepted request; registered.

## Operation
- Reset values: state IDLE, `mem_ready`=0, `mem_rdata`=0, counter=0. The line store is not reset; its contents are undefined until written.
- A request is valid when `mem_read ^ mem_write`. When both are high, or both are low, there is no request; the block stays in IDLE and nothing is written.
- States:
  - IDLE: on a valid request, latch op, `mem_addr[IDX_W-1:0]` and `mem_wdata`, and load the counter. Go to RESP if LATENCY=1, otherwise go to BUSY.
  - BUSY: decrement the counter and enter RESP so that `mem_ready` falls exactly in request cycle LATENCY. Address, data and op changes on inputs are ignored because the latched copies are used.
  - RESP: `mem_ready`=1 for this one cycle, then return to IDLE unconditionally.
- Abort: if `mem_read` and `mem_write` are both low in a BUSY cycle, go to IDLE, raise no `mem_ready`, and write nothing.
- Read: `mem_rdata` loads from store[latched idx] on the edge entering RESP. It holds that value until the next read's RESP, and writes do not change it.
- Write: store[latched idx] ← latched wdata on the edge that ends the RESP cycle. There are no partial writes.
- Address bits [ADDR_W-1:IDX_W] are ignored, so addresses alias modulo 2^IDX_W.
- The counter is 4 bits wide with no wrap-around. The counter is only loaded in IDLE.

## Timing
- Cycle numbering: C0 is the first cycle in which a valid request is high while in IDLE. `mem_ready` is high in C_LATENCY only.
- Back-to-back: the cycle after RESP is IDLE, and a request present there is accepted as its C0. A write-back followed by a refill therefore costs 2·LATENCY+1 cycles from the write's C0 to the read's ready.
- Write followed by read of the same index, back-to-back: the read returns the new data, because the write is committed before the read samples the store.
- A request arriving during BUSY or RESP from another source is not queued. The requester must hold it, and it is accepted at the next IDLE.
- Reset mid-operation (async): `mem_ready` drops immediately and `mem_rdata` clears. Any pending write is discarded, and store contents already written are kept.
- A request held through reset release is accepted in the first post-reset cycle as C0.

## Test plan
- Write then read, LATENCY=4: write addr 0x0000005, data 0x…DEADBEEF_0000F625_12345678_9ABCDEF0 → `mem_ready` in C4 only. The following read of 0x0000005 → ready in C4, `mem_rdata` equals the written line.
- Back-to-back write-back + refill: write to idx 3 (returns ready in C4), `mem_read` idx 7 asserted in C5 → read ready in C9, `mem_rdata` equals the prior contents of idx 7, idx 3 updated.
- Illegal and idle inputs: `mem_read`=`mem_write`=1 for 10 cycles → `mem_ready` never rises, store unchanged.
- Abort: read issued, request dropped in C2 → no `mem_ready`, `mem_rdata` keeps its previous value; a subsequent write issued next is accepted normally.
- Aliasing and latency sweep: LATENCY ∈ {1,2,15}; write addr 0x0000100 and read addr 0x0000000 (IDX_W=8) → same line returned, ready exactly in C_LATENCY.
- Async reset in C2 of a write → outputs 0 within the same cycle, target line keeps its old data, and a request held after reset release is served with ready at C_LATENCY.
